// File: rtl/cavlc_dec_defines.sv
// Shared definitions for the CAVLC coeff_token decoder: nC classes, FSM states,
// the Table 9-5 code tables (indexed by TotalCoeff*4 + TrailingOnes) and helpers.
package cavlc_dec_defines;

  localparam int WIN_W = 16;

  localparam logic [2:0] NC_0_2 = 3'b000;
  localparam logic [2:0] NC_2_4 = 3'b001;
  localparam logic [2:0] NC_4_8 = 3'b010;
  localparam logic [2:0] NC_8UP = 3'b011;
  localparam logic [2:0] NC_CDC = 3'b111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LZC    = 2'd1,
    LOOKUP = 2'd2,
    DONE   = 2'd3
  } state_e;

  // Code length 0 marks a (TotalCoeff, TrailingOnes) pair with no code.
  localparam int LUMA_LEN [0:2][0:67] = '{
    '{ 1, 0, 0, 0,  6, 2, 0, 0,  8, 6, 3, 0,  9, 8, 7, 5, 10, 9, 8, 6, 11,10, 9, 7,
      13,11,10, 8, 13,13,11, 9, 13,13,13,10, 14,14,13,11, 14,14,14,13, 15,15,14,14,
      15,15,15,14, 16,15,15,15, 16,16,16,15, 16,16,16,16, 16,16,16,16},
    '{ 2, 0, 0, 0,  6, 2, 0, 0,  6, 5, 3, 0,  7, 6, 6, 4,  8, 6, 6, 4,  8, 7, 7, 5,
       9, 8, 8, 6, 11, 9, 9, 6, 11,11,11, 7, 12,11,11, 9, 12,12,12,11, 12,12,12,11,
      13,13,13,12, 13,13,13,13, 13,14,13,13, 14,14,14,13, 14,14,14,14},
    '{ 4, 0, 0, 0,  6, 4, 0, 0,  6, 5, 4, 0,  6, 5, 5, 4,  7, 5, 5, 4,  7, 5, 5, 4,
       7, 6, 6, 4,  7, 6, 6, 4,  8, 7, 7, 5,  8, 8, 7, 6,  9, 8, 8, 7,  9, 9, 8, 8,
       9, 9, 9, 8, 10, 9, 9, 9, 10,10,10,10, 10,10,10,10, 10,10,10,10}
  };

  localparam int LUMA_BITS [0:2][0:67] = '{
    '{ 1, 0, 0, 0,  5, 1, 0, 0,  7, 4, 1, 0,  7, 6, 5, 3,  7, 6, 5, 3,  7, 6, 5, 4,
      15, 6, 5, 4, 11,14, 5, 4,  8,10,13, 4, 15,14, 9, 4, 11,10,13,12, 15,14, 9,12,
      11,10,13, 8, 15, 1, 9,12, 11,14,13, 8,  7,10, 9,12,  4, 6, 5, 8},
    '{ 3, 0, 0, 0, 11, 2, 0, 0,  7, 7, 3, 0,  7,10, 9, 5,  7, 6, 5, 4,  4, 6, 5, 6,
       7, 6, 5, 8, 15, 6, 5, 4, 11,14,13, 4, 15,10, 9, 4, 11,14,13,12,  8,10, 9, 8,
      15,14,13,12, 11,10, 9,12,  7,11, 6, 8,  9, 8,10, 1,  7, 6, 5, 4},
    '{15, 0, 0, 0, 15,14, 0, 0, 11,15,13, 0,  8,12,14,12, 15,10,11,11, 11, 8, 9,10,
       9,14,13, 9,  8,10, 9, 8, 15,14,13,13, 11,14,10,12, 15,10,13,12, 11,14, 9,12,
       8,10,13, 8, 13, 7, 9,12,  9,12,11,10,  5, 8, 7, 6,  1, 4, 3, 2}
  };

  localparam int CDC_LEN  [0:19] = '{2, 0, 0, 0, 6, 1, 0, 0, 6, 6, 3, 0, 6, 7, 7, 6, 6, 8, 8, 7};
  localparam int CDC_BITS [0:19] = '{1, 0, 0, 0, 7, 1, 0, 0, 4, 6, 1, 0, 3, 3, 2, 5, 2, 3, 2, 0};

  // Leading zeros of the window, saturated at 15 (an all-zero window also gives 15).
  function automatic logic [3:0] lzc_sat(input logic [WIN_W-1:0] w);
    logic [3:0] n;
    n = 4'd15;
    for (int i = 0; i < WIN_W; i++) begin
      n = w[i] ? 4'(WIN_W - 1 - i) : n;
    end
    return n;
  endfunction

  // Four bits following the first 1; positions past the window end read as 0.
  function automatic logic [3:0] suffix_of(input logic [WIN_W-1:0] w, input logic [3:0] lz);
    logic [3:0] s;
    int         p;
    s = 4'd0;
    for (int k = 0; k < 4; k++) begin
      p = int'(lz) + 1 + k;
      s[3-k] = (p <= WIN_W - 1) ? w[WIN_W - 1 - p] : 1'b0;
    end
    return s;
  endfunction

  // A code hits when its bits equal the head of the rebuilt window; codes longer
  // than lz+1+4 cannot be resolved from the suffix and never occur in the tables.
  function automatic logic code_hit(input logic [WIN_W-1:0] cand, input logic [3:0] lz,
                                    input int len, input int code);
    logic hit;
    if (len == 0 || len > int'(lz) + 5) begin
      hit = 1'b0;
    end else begin
      hit = (int'(cand >> (WIN_W - len)) == code);
    end
    return hit;
  endfunction

endpackage

// File: rtl/coeff_token_dec_rom.sv
// Combinational coeff_token table: maps {nc, leading zeros, suffix} to
// TotalCoeff, TrailingOnes and code length for the VLC classes.
module coeff_token_dec_rom
  import cavlc_dec_defines::*;
(
  input  logic [2:0] nc,
  input  logic [3:0] lz,
  input  logic [3:0] suffix,
  output logic [4:0] total_coeff,
  output logic [1:0] trail_ones,
  output logic [4:0] code_len,
  output logic       match
);

  logic [WIN_W-1:0] cand;
  logic             hit;

  // Table search; the codes are prefix-free so at most one entry hits.
  always_comb begin
    total_coeff = 5'd0;
    trail_ones  = 2'd0;
    code_len    = 5'd0;
    match       = 1'b0;
    hit         = 1'b0;
    cand        = {1'b1, suffix, 11'd0} >> lz;
    case (nc)
      NC_0_2, NC_2_4, NC_4_8: begin
        for (int i = 0; i < 68; i++) begin
          hit         = code_hit(cand, lz, LUMA_LEN[nc[1:0]][i], LUMA_BITS[nc[1:0]][i]);
          total_coeff = hit ? 5'(i / 4) : total_coeff;
          trail_ones  = hit ? 2'(i % 4) : trail_ones;
          code_len    = hit ? 5'(LUMA_LEN[nc[1:0]][i]) : code_len;
          match       = match | hit;
        end
      end
      NC_CDC: begin
        for (int i = 0; i < 20; i++) begin
          hit         = code_hit(cand, lz, CDC_LEN[i], CDC_BITS[i]);
          total_coeff = hit ? 5'(i / 4) : total_coeff;
          trail_ones  = hit ? 2'(i % 4) : trail_ones;
          code_len    = hit ? 5'(CDC_LEN[i]) : code_len;
          match       = match | hit;
        end
      end
      default: begin
        match = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/coeff_token_dec.sv
// CAVLC coeff_token decoder: IDLE -> LZC -> LOOKUP -> DONE, result held under
// a valid/ready handshake. nC>=8 uses the fixed-length 6-bit code.
module coeff_token_dec
  import cavlc_dec_defines::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       nc,
  input  logic [WIN_W-1:0] bits,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       total_coeff,
  output logic [1:0]       trail_ones,
  output logic [4:0]       code_len,
  output logic             err
);

  state_e           state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [2:0]       nc_q, nc_d;
  logic [3:0]       lz_q, lz_d;
  logic [4:0]       tc_q, tc_d;
  logic [1:0]       t1_q, t1_d;
  logic [4:0]       len_q, len_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;

  logic [3:0]       suffix;
  logic [4:0]       rom_tc;
  logic [1:0]       rom_t1;
  logic [4:0]       rom_len;
  logic             rom_match;
  logic [4:0]       flc_tc;

  assign suffix = suffix_of(win_q, lz_q);

  coeff_token_dec_rom u_rom (
    .nc          (nc_q),
    .lz          (lz_q),
    .suffix      (suffix),
    .total_coeff (rom_tc),
    .trail_ones  (rom_t1),
    .code_len    (rom_len),
    .match       (rom_match)
  );

  // Next-state and result computation.
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    nc_d    = nc_q;
    lz_d    = lz_q;
    tc_d    = tc_q;
    t1_d    = t1_q;
    len_d   = len_q;
    err_d   = err_q;
    flc_tc  = {1'b0, win_q[15:12]} + 5'd1;
    case (state_q)
      IDLE: begin
        if (start) begin
          win_d   = bits;
          nc_d    = nc;
          state_d = LZC;
        end else begin
          state_d = IDLE;
        end
      end
      LZC: begin
        lz_d    = lzc_sat(win_q);
        state_d = LOOKUP;
      end
      LOOKUP: begin
        state_d = DONE;
        tc_d    = 5'd0;
        t1_d    = 2'd0;
        len_d   = 5'd0;
        err_d   = 1'b1;
        if (nc_q == NC_8UP) begin
          // 000011 is the only TotalCoeff=0 code; otherwise {TotalCoeff-1, TrailingOnes}.
          if (win_q[15:10] == 6'b000011) begin
            len_d = 5'd6;
            err_d = 1'b0;
          end else if ({3'b000, win_q[11:10]} > flc_tc) begin
            err_d = 1'b1;
          end else begin
            tc_d  = flc_tc;
            t1_d  = win_q[11:10];
            len_d = 5'd6;
            err_d = 1'b0;
          end
        end else if (win_q == {WIN_W{1'b0}}) begin
          err_d = 1'b1;
        end else if (rom_match) begin
          tc_d  = rom_tc;
          t1_d  = rom_t1;
          len_d = rom_len;
          err_d = 1'b0;
        end else begin
          err_d = 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          tc_d    = 5'd0;
          t1_d    = 2'd0;
          len_d   = 5'd0;
          err_d   = 1'b0;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= {WIN_W{1'b0}};
      nc_q    <= 3'd0;
      lz_q    <= 4'd0;
      tc_q    <= 5'd0;
      t1_q    <= 2'd0;
      len_q   <= 5'd0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      nc_q    <= nc_d;
      lz_q    <= lz_d;
      tc_q    <= tc_d;
      t1_q    <= t1_d;
      len_q   <= len_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign out_valid   = valid_q;
  assign total_coeff = tc_q;
  assign trail_ones  = t1_q;
  assign code_len    = len_q;
  assign err         = err_q;

endmodule

// File: tb/tb_coeff_token_dec.sv
// Bench for coeff_token_dec: directed vector table, handshake/reset sequences,
// and random windows checked against a prefix-matching code-table model.
module tb_coeff_token_dec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        out_ready = 1'b0;
  logic [2:0]  nc = 3'd0;
  logic [15:0] bits = 16'd0;
  logic        busy, out_valid, err;
  logic [4:0]  total_coeff, code_len;
  logic [1:0]  trail_ones;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  coeff_token_dec dut (
    .clk(clk), .rst_n(rst_n), .start(start), .nc(nc), .bits(bits),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .total_coeff(total_coeff), .trail_ones(trail_ones), .code_len(code_len), .err(err)
  );

  // Reference code tables: length and value of each code, index TotalCoeff*4+TrailingOnes.
  localparam int T_LEN [0:2][0:67] = '{
    '{ 1, 0, 0, 0,  6, 2, 0, 0,  8, 6, 3, 0,  9, 8, 7, 5, 10, 9, 8, 6, 11,10, 9, 7,
      13,11,10, 8, 13,13,11, 9, 13,13,13,10, 14,14,13,11, 14,14,14,13, 15,15,14,14,
      15,15,15,14, 16,15,15,15, 16,16,16,15, 16,16,16,16, 16,16,16,16},
    '{ 2, 0, 0, 0,  6, 2, 0, 0,  6, 5, 3, 0,  7, 6, 6, 4,  8, 6, 6, 4,  8, 7, 7, 5,
       9, 8, 8, 6, 11, 9, 9, 6, 11,11,11, 7, 12,11,11, 9, 12,12,12,11, 12,12,12,11,
      13,13,13,12, 13,13,13,13, 13,14,13,13, 14,14,14,13, 14,14,14,14},
    '{ 4, 0, 0, 0,  6, 4, 0, 0,  6, 5, 4, 0,  6, 5, 5, 4,  7, 5, 5, 4,  7, 5, 5, 4,
       7, 6, 6, 4,  7, 6, 6, 4,  8, 7, 7, 5,  8, 8, 7, 6,  9, 8, 8, 7,  9, 9, 8, 8,
       9, 9, 9, 8, 10, 9, 9, 9, 10,10,10,10, 10,10,10,10, 10,10,10,10}
  };
  localparam int T_BITS [0:2][0:67] = '{
    '{ 1, 0, 0, 0,  5, 1, 0, 0,  7, 4, 1, 0,  7, 6, 5, 3,  7, 6, 5, 3,  7, 6, 5, 4,
      15, 6, 5, 4, 11,14, 5, 4,  8,10,13, 4, 15,14, 9, 4, 11,10,13,12, 15,14, 9,12,
      11,10,13, 8, 15, 1, 9,12, 11,14,13, 8,  7,10, 9,12,  4, 6, 5, 8},
    '{ 3, 0, 0, 0, 11, 2, 0, 0,  7, 7, 3, 0,  7,10, 9, 5,  7, 6, 5, 4,  4, 6, 5, 6,
       7, 6, 5, 8, 15, 6, 5, 4, 11,14,13, 4, 15,10, 9, 4, 11,14,13,12,  8,10, 9, 8,
      15,14,13,12, 11,10, 9,12,  7,11, 6, 8,  9, 8,10, 1,  7, 6, 5, 4},
    '{15, 0, 0, 0, 15,14, 0, 0, 11,15,13, 0,  8,12,14,12, 15,10,11,11, 11, 8, 9,10,
       9,14,13, 9,  8,10, 9, 8, 15,14,13,13, 11,14,10,12, 15,10,13,12, 11,14, 9,12,
       8,10,13, 8, 13, 7, 9,12,  9,12,11,10,  5, 8, 7, 6,  1, 4, 3, 2}
  };
  localparam int C_LEN  [0:19] = '{2, 0, 0, 0, 6, 1, 0, 0, 6, 6, 3, 0, 6, 7, 7, 6, 6, 8, 8, 7};
  localparam int C_BITS [0:19] = '{1, 0, 0, 0, 7, 1, 0, 0, 4, 6, 1, 0, 3, 3, 2, 5, 2, 3, 2, 0};

  typedef struct {
    logic [2:0]  n;
    logic [15:0] w;
    int          tc;
    int          t1;
    int          len;
    int          e;
  } vec_t;

  vec_t vecs [0:16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int entry_len(input logic [2:0] n, input int i);
    return (n == 3'b111) ? C_LEN[i] : T_LEN[int'(n[1:0])][i];
  endfunction

  function automatic int entry_bits(input logic [2:0] n, input int i);
    return (n == 3'b111) ? C_BITS[i] : T_BITS[int'(n[1:0])][i];
  endfunction

  // Decode by matching each code against the head of the full window.
  function automatic void model(input logic [2:0] n, input logic [15:0] w,
                                output int tc, output int t1, output int len, output int e);
    int a, b, cnt, l;
    tc = 0; t1 = 0; len = 0; e = 1;
    if (n == 3'b011) begin
      a = int'(w[15:12]);
      b = int'(w[11:10]);
      if (w[15:10] == 6'b000011) begin
        len = 6; e = 0;
      end else if (b <= a + 1) begin
        tc = a + 1; t1 = b; len = 6; e = 0;
      end
    end else if ((n <= 3'd2 || n == 3'b111) && w != 16'd0) begin
      cnt = (n == 3'b111) ? 20 : 68;
      for (int i = 0; i < cnt; i++) begin
        l = entry_len(n, i);
        if (l != 0 && int'(w >> (16 - l)) == entry_bits(n, i)) begin
          tc = i / 4; t1 = i % 4; len = l; e = 0;
        end
      end
    end
  endfunction

  task automatic issue(input logic [2:0] n, input logic [15:0] w);
    nc = n;
    bits = w;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
  endtask

  // Edges after acceptance until out_valid; expected two (valid in the third cycle after start).
  task automatic wait_valid(input string name);
    int c;
    c = 0;
    while (!out_valid && c < 20) begin
      @(posedge clk); #1;
      c++;
    end
    chk({name, "_latency"}, c, 2);
  endtask

  task automatic check_out(input string name, input int tc, input int t1, input int len, input int e);
    chk({name, "_tc"}, int'(total_coeff), tc);
    chk({name, "_t1"}, int'(trail_ones), t1);
    chk({name, "_len"}, int'(code_len), len);
    chk({name, "_err"}, int'(err), e);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("valid_drop", int'(out_valid), 0);
    chk("err_clear", int'(err), 0);
    chk("busy_idle", int'(busy), 0);
  endtask

  initial begin
    int etc, et1, elen, ee, r, idx, l, hold;
    logic [2:0]  rn;
    logic [15:0] rw;

    vecs[0]  = '{3'b000, 16'h8000, 0, 0, 1, 0};
    vecs[1]  = '{3'b000, 16'h4000, 1, 1, 2, 0};
    vecs[2]  = '{3'b000, 16'h2000, 2, 2, 3, 0};
    vecs[3]  = '{3'b000, 16'h1400, 1, 0, 6, 0};
    vecs[4]  = '{3'b011, 16'h0C00, 0, 0, 6, 0};
    vecs[5]  = '{3'b011, 16'h5800, 6, 2, 6, 0};
    vecs[6]  = '{3'b111, 16'h4000, 0, 0, 2, 0};
    vecs[7]  = '{3'b111, 16'h8000, 1, 1, 1, 0};
    vecs[8]  = '{3'b010, 16'hF000, 0, 0, 4, 0};
    vecs[9]  = '{3'b000, 16'h0000, 0, 0, 0, 1};
    vecs[10] = '{3'b100, 16'h8000, 0, 0, 0, 1};
    vecs[11] = '{3'b011, 16'h0800, 0, 0, 0, 1};
    vecs[12] = '{3'b001, 16'hC000, 0, 0, 2, 0};
    vecs[13] = '{3'b111, 16'h0000, 0, 0, 0, 1};
    vecs[14] = '{3'b111, 16'h0100, 4, 3, 7, 0};
    vecs[15] = '{3'b000, 16'h0001, 0, 0, 0, 1};
    vecs[16] = '{3'b000, 16'h0008, 16, 3, 16, 0};

    #1;
    check_out("reset", 0, 0, 0, 0);
    chk("reset_valid", int'(out_valid), 0);
    chk("reset_busy", int'(busy), 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 17; v++) begin
      issue(vecs[v].n, vecs[v].w);
      wait_valid("vec");
      check_out($sformatf("vec%0d", v), vecs[v].tc, vecs[v].t1, vecs[v].len, vecs[v].e);
      handshake();
    end

    // Backpressure with a start pulse while DONE.
    issue(3'b000, 16'h2000);
    wait_valid("bp");
    for (int k = 0; k < 5; k++) begin
      start = (k == 1);
      nc = 3'b000;
      bits = 16'h8000;
      @(posedge clk); #1;
      start = 1'b0;
      check_out("bp_hold", 2, 2, 3, 0);
      chk("bp_valid", int'(out_valid), 1);
      chk("bp_busy", int'(busy), 1);
    end
    handshake();
    @(posedge clk); #1;
    chk("bp_no_restart", int'(busy), 0);
    issue(3'b000, 16'h8000);
    wait_valid("bp_next");
    check_out("bp_next", 0, 0, 1, 0);
    handshake();

    // Reset during LOOKUP, then during DONE.
    issue(3'b000, 16'h4000);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_lookup_busy", int'(busy), 0);
    chk("rst_lookup_valid", int'(out_valid), 0);
    check_out("rst_lookup", 0, 0, 0, 0);
    rst_n = 1'b1;
    issue(3'b000, 16'h2000);
    wait_valid("rst_done_pre");
    rst_n = 1'b0;
    #1;
    chk("rst_done_valid", int'(out_valid), 0);
    check_out("rst_done", 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk("rst_idle_valid", int'(out_valid), 0);
      chk("rst_idle_busy", int'(busy), 0);
    end
    issue(3'b001, 16'h8000);
    wait_valid("post_rst");
    check_out("post_rst", 1, 1, 2, 0);
    handshake();

    // Random windows: half built from a real code plus random tail.
    for (int it = 0; it < 400; it++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1: rn = 3'b000;
        2, 3: rn = 3'b001;
        4, 5: rn = 3'b010;
        6:    rn = 3'b011;
        7, 8: rn = 3'b111;
        default: rn = 3'($urandom_range(4, 6));
      endcase
      rw = 16'($urandom) >> $urandom_range(0, 16);
      if ((rn <= 3'd2 || rn == 3'b111) && $urandom_range(0, 1) == 1) begin
        for (int t = 0; t < 50; t++) begin
          idx = int'($urandom_range(0, (rn == 3'b111) ? 19 : 67));
          l = entry_len(rn, idx);
          if (l != 0) break;
        end
        if (l != 0) begin
          rw = 16'((entry_bits(rn, idx) << (16 - l)) | (int'($urandom) & ((1 << (16 - l)) - 1)));
        end
      end
      model(rn, rw, etc, et1, elen, ee);
      issue(rn, rw);
      wait_valid("rnd");
      hold = int'($urandom_range(0, 2));
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
      end
      check_out($sformatf("rnd nc=%0d w=%04h", rn, rw), etc, et1, elen, ee);
      handshake();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
